alu_result_stage: RTL and testbench

//  Registered execution stage directly downstream of operand preprocessing in the 4-bit ALU.

---
 rtl/alu_result_stage.sv | 127 ++++++++++++
 tb/tb_alu_result_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered 4-bit ALU execution stage with valid/ready output.
// The stage computes the result and N/Z/C/V flags from AMod/BMod/Op.
// It holds the result in a one-entry output register and counts completed transfers.
// Optional feature macro: ALU_STICKY_OVF_EN adds a sticky overflow flag.
//   state   | meaning
//   S_EMPTY | no result held, out_valid=0
//   S_FULL  | result held in R/flags, out_valid=1
module alu_result_stage #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     AMod,
  input  logic [W-1:0]     BMod,
  input  logic [2:0]       Op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     R,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     r_q, r_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             capture;
  logic             xfer;
  logic [W:0]       sum;
  logic [W-1:0]     res;
  logic             c_res;
  logic             v_res;

  // Combinational ALU: arithmetic for Op[2]=0, bitwise ops otherwise.
  always_comb begin
    sum   = {1'b0, AMod} + {1'b0, BMod};
    res   = '0;
    c_res = 1'b0;
    v_res = 1'b0;
    if (!Op[2]) begin
      res   = sum[W-1:0];
      c_res = sum[W];
      // Signed overflow: like-signed operands yielding a result of the other sign.
      v_res = (AMod[W-1] == BMod[W-1]) && (sum[W-1] != AMod[W-1]);
    end else begin
      case (Op[1:0])
        2'b00:   res = AMod & BMod;
        2'b01:   res = AMod | BMod;
        2'b10:   res = AMod ^ BMod;
        default: res = ~AMod;
      endcase
    end
  end

  // Handshake, next-state and output-register next values.
  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    flags_d  = flags_q;
    in_ready = (state_q == S_EMPTY) || out_ready;
    capture  = in_valid && in_ready;
    xfer     = (state_q == S_FULL) && out_ready;
    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, xfer};
    case (state_q)
      S_EMPTY: if (capture) state_d = S_FULL;
      S_FULL:  if (out_ready && !capture) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (capture) begin
      r_d     = res;
      flags_d = {res[W-1], (res == '0), c_res, v_res};
    end
  end

  // State, result, flags and transfer counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      r_q     <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign R         = r_q;
  assign flags     = flags_q;
  assign out_valid = (state_q == S_FULL);
  assign op_count  = cnt_q;

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q;

  // Sticky overflow: a V=1 capture takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (capture && v_res) begin
      sticky_q <= 1'b1;
    end else if (ovf_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign ovf_sticky = sticky_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed cases plus random traffic against a
// transaction-level model (held result, transfer count, sticky overflow).
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] AMod = '0, BMod = '0;
  logic [2:0] Op = '0;
  logic       in_valid = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic       in_ready, out_valid, ovf_sticky;
  logic [3:0] R, flags;
  logic [7:0] op_count;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit         m_valid = 0;
  int         m_r = 0;
  logic [3:0] m_f = '0;
  int         m_cnt = 0;
  bit         m_st = 0;

  alu_result_stage #(.W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .AMod(AMod), .BMod(BMod), .Op(Op),
    .in_valid(in_valid), .in_ready(in_ready), .R(R), .flags(flags),
    .out_valid(out_valid), .out_ready(out_ready), .op_count(op_count),
    .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU from the arithmetic definition (integer and signed-range view).
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output logic [3:0] f);
    int sa, sb, sum;
    bit c, v;
    c = 0; v = 0;
    if (op < 4) begin
      sum = a + b;
      r   = sum % 16;
      c   = (sum > 15);
      sa  = (a > 7) ? a - 16 : a;
      sb  = (b > 7) ? b - 16 : b;
      v   = (sa + sb > 7) || (sa + sb < -8);
    end else if (op == 4) r = a & b;
    else if (op == 5) r = a | b;
    else if (op == 6) r = a ^ b;
    else r = 15 - a;
    f = {r >= 8, r == 0, c, v};
  endfunction

  // One cycle: check held outputs, drive inputs, check in_ready, advance the model.
  task automatic step(input bit iv, input int op, input int a, input int b,
                      input bit ordy, input bit clr);
    int r;
    logic [3:0] f;
    bit rdy;
    @(negedge clk);
    check_eq("out_valid", out_valid, m_valid);
    check_eq("R", R, m_r);
    check_eq("flags", flags, m_f);
    check_eq("op_count", op_count, m_cnt);
    check_eq("ovf_sticky", ovf_sticky, m_st);
    in_valid = iv; Op = op[2:0]; AMod = a[3:0]; BMod = b[3:0];
    out_ready = ordy; ovf_clr = clr;
    #1;
    rdy = !m_valid || ordy;
    check_eq("in_ready", in_ready, rdy);
    if (m_valid && ordy) m_cnt = (m_cnt + 1) % 256;
    ref_alu(op, a, b, r, f);
`ifdef ALU_STICKY_OVF_EN
    if (iv && rdy && f[0]) m_st = 1;
    else if (clr) m_st = 0;
`endif
    if (iv && rdy) begin
      m_r = r; m_f = f; m_valid = 1;
    end else if (ordy) begin
      m_valid = 0;
    end
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    #12;
    rst_n = 1'b1;

    // Add overflow: 0111 + 0001
    step(1, 0, 7, 1, 1, 0);
    after_edge();
    check_eq("t2_R", R, 4'b1000);
    check_eq("t2_flags", flags, 4'b1001);
    check_eq("t2_valid", out_valid, 1'b1);
`ifdef ALU_STICKY_OVF_EN
    check_eq("t2_sticky", ovf_sticky, 1'b1);
`endif

    // Arithmetic with negative operand, then wrap to zero
    step(1, 2, 1, 12, 1, 0);
    after_edge();
    check_eq("t3a_R", R, 4'b1101);
    check_eq("t3a_flags", flags, 4'b1000);
    step(1, 2, 1, 15, 1, 0);
    after_edge();
    check_eq("t3b_R", R, 4'b0000);
    check_eq("t3b_flags", flags, 4'b0110);

    // Logic ops
    step(1, 4, 12, 10, 1, 0);
    after_edge();
    check_eq("t4_and_R", R, 4'b1000);
    check_eq("t4_and_flags", flags, 4'b1000);
    step(1, 6, 12, 10, 1, 0);
    after_edge();
    check_eq("t4_xor_R", R, 4'b0110);
    check_eq("t4_xor_flags", flags, 4'b0000);
`ifdef ALU_STICKY_OVF_EN
    check_eq("sticky_hold", ovf_sticky, 1'b1);
    step(0, 0, 0, 0, 1, 1);
    after_edge();
    check_eq("sticky_clr", ovf_sticky, 1'b0);
    step(1, 0, 7, 1, 1, 1);
    after_edge();
    check_eq("sticky_set_wins", ovf_sticky, 1'b1);
`endif

    // Backpressure: first op held, second op stalled then captured
    step(1, 5, 3, 4, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 7, 5, 0, 0, 0);
      check_eq("bp_in_ready", in_ready, 1'b0);
    end
    after_edge();
    check_eq("bp_R_held", R, 4'b0111);
    step(1, 7, 5, 0, 1, 0);
    after_edge();
    check_eq("bp_R_new", R, 4'b1010);
    check_eq("bp_valid", out_valid, 1'b1);

    // Mid-cycle reset clears outputs with no clock edge
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("rst_R", R, 4'b0000);
    check_eq("rst_flags", flags, 4'b0000);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_cnt", op_count, 8'd0);
    check_eq("rst_sticky", ovf_sticky, 1'b0);
    m_valid = 0; m_r = 0; m_f = '0; m_cnt = 0; m_st = 0;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;

    // 256 transfers wrap the counter back to 0
    for (int i = 0; i < 257; i++) step(1, i % 8, i % 16, (i * 7) % 16, 1, 0);
    after_edge();
    check_eq("cnt_wrap", op_count, 8'd0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, $urandom % 8, $urandom % 16, $urandom % 16,
           ($urandom % 10) < 7, ($urandom % 8) == 0);
    step(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
